// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/DMA memory arbiter: FSM encoding, latency
// limits and the latency-counter load helper.
package mem_arbiter_pkg;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CNT_W   = 3;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CPU_ACC  = 2'd1;
  localparam logic [1:0] ST_DMA_ACC  = 2'd2;
  localparam logic [1:0] ST_COOLDOWN = 2'd3;

  // Writes finish in the enable cycle, so they load zero and complete at once.
  function automatic logic [LAT_CNT_W-1:0] lat_load_val(input logic we, input int lat);
    return we ? '0 : lat[LAT_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU, DMA and memory-side signals of the arbiter. The slave
// modport is the arbiter's view; master is the view of whatever drives it.
interface mem_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              i_MIO_EN;
  logic              i_R_W;
  logic [ADDR_W-1:0] i_MAR;
  logic [DATA_W-1:0] i_MDR;
  logic              o_Ready_Bit;
  logic [DATA_W-1:0] o_CPU_Rd_Data;
  logic              i_DMA_Valid;
  logic              i_DMA_We;
  logic [ADDR_W-1:0] i_DMA_Addr;
  logic [DATA_W-1:0] i_DMA_Wr_Data;
  logic              o_DMA_Ready;
  logic [DATA_W-1:0] o_DMA_Rd_Data;
  logic              o_Mem_En;
  logic              o_Mem_We;
  logic [ADDR_W-1:0] o_Mem_Addr;
  logic [DATA_W-1:0] o_Mem_Wr_Data;
  logic [DATA_W-1:0] i_Mem_Rd_Data;

  modport slave (
    input  i_MIO_EN, i_R_W, i_MAR, i_MDR,
    input  i_DMA_Valid, i_DMA_We, i_DMA_Addr, i_DMA_Wr_Data,
    input  i_Mem_Rd_Data,
    output o_Ready_Bit, o_CPU_Rd_Data, o_DMA_Ready, o_DMA_Rd_Data,
    output o_Mem_En, o_Mem_We, o_Mem_Addr, o_Mem_Wr_Data
  );

  modport master (
    output i_MIO_EN, i_R_W, i_MAR, i_MDR,
    output i_DMA_Valid, i_DMA_We, i_DMA_Addr, i_DMA_Wr_Data,
    output i_Mem_Rd_Data,
    input  o_Ready_Bit, o_CPU_Rd_Data, o_DMA_Ready, o_DMA_Rd_Data,
    input  o_Mem_En, o_Mem_We, o_Mem_Addr, o_Mem_Wr_Data
  );
endinterface

// File: rtl/mem_arbiter_lat_counter.sv
// Loadable down-counter timing an access; o_done is high while the count is zero.
module mem_lat_counter
  import mem_arbiter_pkg::*;
(
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  input  logic                 i_load,
  input  logic [LAT_CNT_W-1:0] i_load_val,
  input  logic                 i_dec,
  output logic                 o_done
);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - LAT_CNT_W'(1);
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU
// microsequencer and a DMA engine; one access at a time, all outputs registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 2
) (
  input logic          i_CLK,
  input logic          i_RST_N,
  mem_arbiter_if.slave bus
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be within 1..4");
  end

  state_t              state_q, state_d;
  logic                rr_dma_q, rr_dma_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic                cpu_rdy_q, cpu_rdy_d;
  logic                dma_rdy_q, dma_rdy_d;
  logic [DATA_W-1:0]   cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0]   dma_rd_q, dma_rd_d;

  logic                pick_dma;
  logic                in_acc;
  logic                lat_load_en;
  logic [LAT_CNT_W-1:0] lat_val;
  logic                lat_done;

  assign in_acc = (state_q == ST_CPU_ACC) || (state_q == ST_DMA_ACC);

  mem_lat_counter u_lat (
    .i_CLK      (i_CLK),
    .i_RST_N    (i_RST_N),
    .i_load     (lat_load_en),
    .i_load_val (lat_val),
    .i_dec      (in_acc),
    .o_done     (lat_done)
  );

  always_comb begin
    state_d       = state_q;
    rr_dma_d      = rr_dma_q;
    mem_en_d      = 1'b0;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    cpu_rdy_d     = 1'b0;
    dma_rdy_d     = 1'b0;
    cpu_rd_d      = cpu_rd_q;
    dma_rd_d      = dma_rd_q;
    pick_dma      = 1'b0;
    lat_load_en   = 1'b0;
    lat_val       = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_MIO_EN || bus.i_DMA_Valid) begin
          pick_dma = bus.i_DMA_Valid && (!bus.i_MIO_EN || rr_dma_q);
          // The pointer only moves when a tie is actually resolved.
          if (bus.i_MIO_EN && bus.i_DMA_Valid) begin
            rr_dma_d = ~pick_dma;
          end
          state_d       = pick_dma ? ST_DMA_ACC : ST_CPU_ACC;
          mem_en_d      = 1'b1;
          mem_we_d      = pick_dma ? bus.i_DMA_We      : bus.i_R_W;
          mem_addr_d    = pick_dma ? bus.i_DMA_Addr    : bus.i_MAR;
          mem_wr_data_d = pick_dma ? bus.i_DMA_Wr_Data : bus.i_MDR;
          lat_load_en   = 1'b1;
          lat_val       = lat_load_val(mem_we_d, MEM_LAT);
        end
      end
      ST_CPU_ACC, ST_DMA_ACC: begin
        if (lat_done) begin
          state_d = ST_COOLDOWN;
          if (state_q == ST_CPU_ACC) begin
            cpu_rdy_d = 1'b1;
            if (!mem_we_q) cpu_rd_d = bus.i_Mem_Rd_Data;
          end else begin
            dma_rdy_d = 1'b1;
            if (!mem_we_q) dma_rd_d = bus.i_Mem_Rd_Data;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q       <= ST_IDLE;
      rr_dma_q      <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      cpu_rdy_q     <= 1'b0;
      dma_rdy_q     <= 1'b0;
      cpu_rd_q      <= '0;
      dma_rd_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_dma_q      <= rr_dma_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      cpu_rdy_q     <= cpu_rdy_d;
      dma_rdy_q     <= dma_rdy_d;
      cpu_rd_q      <= cpu_rd_d;
      dma_rd_q      <= dma_rd_d;
    end
  end

  assign bus.o_Mem_En      = mem_en_q;
  assign bus.o_Mem_We      = mem_we_q;
  assign bus.o_Mem_Addr    = mem_addr_q;
  assign bus.o_Mem_Wr_Data = mem_wr_data_q;
  assign bus.o_Ready_Bit   = cpu_rdy_q;
  assign bus.o_DMA_Ready   = dma_rdy_q;
  assign bus.o_CPU_Rd_Data = cpu_rd_q;
  assign bus.o_DMA_Rd_Data = dma_rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand-written sequences for round-robin, dropped requests, reset and MEM_LAT=4.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;

  typedef struct {
    bit     dma;
    bit     we;
    integer addr;
    integer wdata;
    integer hold;
    integer exp_rd;
    integer exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(2)) dut_a (
    .i_CLK(clk), .i_RST_N(rst_n), .bus(bus_a)
  );
  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(4)) dut_b (
    .i_CLK(clk), .i_RST_N(rst_n), .bus(bus_b)
  );

  // Memory models: read data appears MEM_LAT cycles after the enable cycle,
  // 16'hDEAD at any other time.
  logic [15:0] mem_a [0:65535];
  logic [15:0] pipe_a [0:1];
  logic [15:0] mem_b [0:65535];
  logic [15:0] pipe_b [0:3];

  assign bus_a.i_Mem_Rd_Data = pipe_a[1];
  assign bus_b.i_Mem_Rd_Data = pipe_b[3];

  initial begin
    for (int i = 0; i < 65536; i++) mem_a[i] = 16'h0000;
    mem_a[16'h3000] = 16'h1234;
    pipe_a[0] = 16'hDEAD;
    pipe_a[1] = 16'hDEAD;
    forever begin
      @(posedge clk);
      pipe_a[0] <= (bus_a.o_Mem_En && !bus_a.o_Mem_We) ? mem_a[bus_a.o_Mem_Addr] : 16'hDEAD;
      pipe_a[1] <= pipe_a[0];
      if (bus_a.o_Mem_En && bus_a.o_Mem_We) mem_a[bus_a.o_Mem_Addr] <= bus_a.o_Mem_Wr_Data;
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem_b[i] = 16'h0000;
    mem_b[16'h0100] = 16'h00AA;
    for (int i = 0; i < 4; i++) pipe_b[i] = 16'hDEAD;
    forever begin
      @(posedge clk);
      pipe_b[0] <= (bus_b.o_Mem_En && !bus_b.o_Mem_We) ? mem_b[bus_b.o_Mem_Addr] : 16'hDEAD;
      for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
      if (bus_b.o_Mem_En && bus_b.o_Mem_We) mem_b[bus_b.o_Mem_Addr] <= bus_b.o_Mem_Wr_Data;
    end
  end

  task automatic check(input string name, input integer act, input integer exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drop_req(input bit dma);
    if (dma) bus_a.i_DMA_Valid = 1'b0;
    else     bus_a.i_MIO_EN    = 1'b0;
  endtask

  // Called right after a negedge; k counts negedges after the request is raised.
  task automatic run_xact(input vec_t v, output integer en_k, output integer rdy_k,
                          output integer en_cnt, output integer rdy_cnt,
                          output integer oth, output integer unst, output integer rd);
    en_k = -1; rdy_k = -1; en_cnt = 0; rdy_cnt = 0; oth = 0; unst = 0; rd = 0;
    if (v.dma) begin
      bus_a.i_DMA_We      = v.we;
      bus_a.i_DMA_Addr    = 16'(v.addr);
      bus_a.i_DMA_Wr_Data = 16'(v.wdata);
      bus_a.i_DMA_Valid   = 1'b1;
    end else begin
      bus_a.i_R_W    = v.we;
      bus_a.i_MAR    = 16'(v.addr);
      bus_a.i_MDR    = 16'(v.wdata);
      bus_a.i_MIO_EN = 1'b1;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus_a.o_Mem_En) begin
        en_cnt++;
        if (en_k < 0) en_k = k;
      end
      if (en_k > 0 && rdy_k < 0 &&
          (bus_a.o_Mem_We !== v.we || bus_a.o_Mem_Addr !== 16'(v.addr) ||
           (v.we && bus_a.o_Mem_Wr_Data !== 16'(v.wdata))))
        unst++;
      if (v.dma ? bus_a.o_Ready_Bit : bus_a.o_DMA_Ready) oth++;
      if (v.dma ? bus_a.o_DMA_Ready : bus_a.o_Ready_Bit) begin
        rdy_cnt++;
        if (rdy_k < 0) begin
          rdy_k = k;
          rd = 32'(v.dma ? bus_a.o_DMA_Rd_Data : bus_a.o_CPU_Rd_Data);
        end
      end
      if (rdy_k > 0 && k == rdy_k + v.hold) drop_req(v.dma);
      if (rdy_k > 0 && k >= rdy_k + v.hold + 3) break;
    end
    drop_req(v.dma);
  endtask

  // Both requesters raise together; records the address of the first two grants.
  task automatic rr_pair(output integer g0, output integer g1, output integer ng);
    g0 = 0; g1 = 0; ng = 0;
    bus_a.i_R_W = 1'b1; bus_a.i_MAR = 16'h5000; bus_a.i_MDR = 16'h1111;
    bus_a.i_DMA_We = 1'b1; bus_a.i_DMA_Addr = 16'h6000; bus_a.i_DMA_Wr_Data = 16'h2222;
    bus_a.i_MIO_EN = 1'b1;
    bus_a.i_DMA_Valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus_a.o_Mem_En) begin
        if (ng == 0) g0 = 32'(bus_a.o_Mem_Addr);
        else if (ng == 1) g1 = 32'(bus_a.o_Mem_Addr);
        ng++;
      end
      if (bus_a.o_Ready_Bit) bus_a.i_MIO_EN = 1'b0;
      if (bus_a.o_DMA_Ready) bus_a.i_DMA_Valid = 1'b0;
    end
    bus_a.i_MIO_EN = 1'b0;
    bus_a.i_DMA_Valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  initial begin
    vec_t   tbl [9];
    integer en_k, rdy_k, en_cnt, rdy_cnt, oth, unst, rd;
    integer g0, g1, ng, cnt, cnt2, cnt3;
    integer last_cpu_rd, last_dma_rd;

    tbl[0] = '{1'b0, 1'b0, 'h3000, 'h0000, 0, 'h1234, 3};
    tbl[1] = '{1'b0, 1'b1, 'h4000, 'hBEEF, 1, 0,      1};
    tbl[2] = '{1'b0, 1'b0, 'h4000, 'h0000, 0, 'hBEEF, 3};
    tbl[3] = '{1'b1, 1'b1, 'h0200, 'h5A5A, 0, 0,      1};
    tbl[4] = '{1'b1, 1'b0, 'h0200, 'h0000, 0, 'h5A5A, 3};
    tbl[5] = '{1'b1, 1'b0, 'h3000, 'h0000, 0, 'h1234, 3};
    tbl[6] = '{1'b0, 1'b0, 'h3000, 'h0000, 1, 'h1234, 3};
    tbl[7] = '{1'b0, 1'b1, 'hFFFF, 'h0001, 0, 0,      1};
    tbl[8] = '{1'b0, 1'b0, 'hFFFF, 'h0000, 0, 'h0001, 3};

    bus_a.i_MIO_EN = 1'b0; bus_a.i_R_W = 1'b0; bus_a.i_MAR = '0; bus_a.i_MDR = '0;
    bus_a.i_DMA_Valid = 1'b0; bus_a.i_DMA_We = 1'b0; bus_a.i_DMA_Addr = '0; bus_a.i_DMA_Wr_Data = '0;
    bus_b.i_MIO_EN = 1'b0; bus_b.i_R_W = 1'b0; bus_b.i_MAR = '0; bus_b.i_MDR = '0;
    bus_b.i_DMA_Valid = 1'b0; bus_b.i_DMA_We = 1'b0; bus_b.i_DMA_Addr = '0; bus_b.i_DMA_Wr_Data = '0;

    repeat (3) @(negedge clk);
    check("reset_ctrl", 32'({bus_a.o_Mem_En, bus_a.o_Mem_We, bus_a.o_Ready_Bit, bus_a.o_DMA_Ready}), 0);
    check("reset_bus", 32'({bus_a.o_Mem_Addr, bus_a.o_Mem_Wr_Data}), 0);
    check("reset_rdata", 32'({bus_a.o_CPU_Rd_Data, bus_a.o_DMA_Rd_Data}), 0);
    rst_n = 1'b1;

    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus_a.o_Mem_En) cnt++;
    end
    check("idle_no_access", cnt, 0);

    last_cpu_rd = 0;
    last_dma_rd = 0;
    for (int i = 0; i < 9; i++) begin
      run_xact(tbl[i], en_k, rdy_k, en_cnt, rdy_cnt, oth, unst, rd);
      check($sformatf("v%0d_grant_next_edge", i), en_k, 1);
      check($sformatf("v%0d_latency", i), rdy_k - en_k, tbl[i].exp_lat);
      check($sformatf("v%0d_one_access", i), en_cnt, 1);
      check($sformatf("v%0d_one_ready", i), rdy_cnt, 1);
      check($sformatf("v%0d_other_ready", i), oth, 0);
      check($sformatf("v%0d_bus_stable", i), unst, 0);
      if (tbl[i].we) begin
        check($sformatf("v%0d_rdata_held", i), rd, tbl[i].dma ? last_dma_rd : last_cpu_rd);
        check($sformatf("v%0d_mem_written", i), 32'(mem_a[16'(tbl[i].addr)]), tbl[i].wdata);
      end else begin
        check($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
        if (tbl[i].dma) last_dma_rd = tbl[i].exp_rd;
        else            last_cpu_rd = tbl[i].exp_rd;
      end
    end

    rr_pair(g0, g1, ng);
    check("rr1_grants", ng, 2);
    check("rr1_first_cpu", g0, 'h5000);
    check("rr1_second_dma", g1, 'h6000);
    rr_pair(g0, g1, ng);
    check("rr2_grants", ng, 2);
    check("rr2_first_dma", g0, 'h6000);
    check("rr2_second_cpu", g1, 'h5000);

    // CPU pulses a request while DMA owns the memory, then withdraws it.
    bus_a.i_DMA_We = 1'b0; bus_a.i_DMA_Addr = 16'h3000; bus_a.i_DMA_Valid = 1'b1;
    cnt = 0; cnt2 = 0; cnt3 = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus_a.o_Mem_En && bus_a.o_Mem_Addr == 16'h7000) cnt++;
      if (bus_a.o_Ready_Bit) cnt2++;
      if (bus_a.o_DMA_Ready) begin
        cnt3++;
        bus_a.i_DMA_Valid = 1'b0;
      end
      if (k == 1) begin
        bus_a.i_R_W = 1'b0; bus_a.i_MAR = 16'h7000; bus_a.i_MIO_EN = 1'b1;
      end
      if (k == 2) bus_a.i_MIO_EN = 1'b0;
    end
    bus_a.i_DMA_Valid = 1'b0;
    check("dropped_no_access", cnt, 0);
    check("dropped_no_ready", cnt2, 0);
    check("dropped_dma_ready", cnt3, 1);

    // Reset in the enable cycle of a CPU read.
    bus_a.i_R_W = 1'b0; bus_a.i_MAR = 16'h3000; bus_a.i_MIO_EN = 1'b1;
    @(negedge clk);
    check("rst_mid_pre_en", 32'(bus_a.o_Mem_En), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", 32'({bus_a.o_Mem_En, bus_a.o_Mem_We, bus_a.o_Ready_Bit, bus_a.o_DMA_Ready}), 0);
    check("rst_mid_bus", 32'({bus_a.o_Mem_Addr, bus_a.o_Mem_Wr_Data}), 0);
    check("rst_mid_rdata", 32'({bus_a.o_CPU_Rd_Data, bus_a.o_DMA_Rd_Data}), 0);
    bus_a.i_MIO_EN = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_a.o_Ready_Bit || bus_a.o_Mem_En) cnt++;
    end
    check("rst_mid_no_ready", cnt, 0);
    rst_n = 1'b1;
    run_xact(tbl[0], en_k, rdy_k, en_cnt, rdy_cnt, oth, unst, rd);
    check("rst_rel_grant_first_edge", en_k, 1);
    check("rst_rel_latency", rdy_k - en_k, 3);
    check("rst_rel_one_ready", rdy_cnt, 1);
    check("rst_rel_rdata", rd, 'h1234);

    // DMA read on the MEM_LAT=4 instance.
    bus_b.i_DMA_We = 1'b0; bus_b.i_DMA_Addr = 16'h0100; bus_b.i_DMA_Valid = 1'b1;
    en_k = -1; rdy_k = -1; en_cnt = 0; rd = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus_b.o_Mem_En) begin
        en_cnt++;
        if (en_k < 0) en_k = k;
      end
      if (bus_b.o_DMA_Ready && rdy_k < 0) begin
        rdy_k = k;
        rd = 32'(bus_b.o_DMA_Rd_Data);
        bus_b.i_DMA_Valid = 1'b0;
      end
    end
    bus_b.i_DMA_Valid = 1'b0;
    check("lat4_grant", en_k, 1);
    check("lat4_latency", rdy_k - en_k, 5);
    check("lat4_one_access", en_cnt, 1);
    check("lat4_rdata", rd, 'h00AA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
